tq_row_gather: RTL and testbench

//  Front end of the forward-transform datapath, directly upstream of the 16-point butterfly.

---
 rtl/tq_pkg.sv | 32 +++
 rtl/tq_row_gather_if.sv | 33 +++
 rtl/tq_row_buf.sv | 54 +++++
 rtl/tq_row_gather.sv | 154 +++++++++++++++
 tb/tb_tq_row_gather.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tq_pkg.sv
// tq_pkg: shared definitions for the transform row gatherer.
//  - size_e      : row size code carried on i_size/o_size (4, 8, 16 samples, reserved)
//  - beats_per_row(size) : number of 4-sample input beats that make one row
//  - rows_per_blk(size)  : number of rows in one square block of that size
package tq_pkg;

   typedef enum logic [1:0] {
      SIZE_4   = 2'd0,
      SIZE_8   = 2'd1,
      SIZE_16  = 2'd2,
      SIZE_RSV = 2'd3
   } size_e;

   // The reserved code maps to a single beat so a stray beat never stalls the row counter.
   function automatic logic [2:0] beats_per_row(input size_e s);
      case (s)
         SIZE_8:  return 3'd2;
         SIZE_16: return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   // A block is N x N, so it holds as many rows as a row holds samples.
   function automatic logic [4:0] rows_per_blk(input size_e s);
      case (s)
         SIZE_8:  return 5'd8;
         SIZE_16: return 5'd16;
         default: return 5'd4;
      endcase
   endfunction

endpackage

// File: rtl/tq_row_gather_if.sv
// tq_row_gather_if: beat input side and row output side of the row gatherer.
//  i_valid/o_ready/i_size/i_data : 4-sample input beats from the residual source
//  o_valid/i_ready               : row handshake towards the butterfly
//  o_size/o_bfly_en/o_row_idx/o_blk_last/o_data : presented row and its position in the block
//  o_err                         : sticky protocol error flag
// slave is the gatherer, master is whoever drives beats and consumes rows.
interface tq_row_gather_if #(
   parameter int IN_W  = 9,
   parameter int OUT_W = 26
);
   logic                  i_valid;
   logic                  o_ready;
   logic [1:0]            i_size;
   logic [4*IN_W-1:0]     i_data;
   logic                  o_valid;
   logic                  i_ready;
   logic [1:0]            o_size;
   logic                  o_bfly_en;
   logic [3:0]            o_row_idx;
   logic                  o_blk_last;
   logic [16*OUT_W-1:0]   o_data;
   logic                  o_err;

   modport slave (
      input  i_valid, i_size, i_data, i_ready,
      output o_ready, o_valid, o_size, o_bfly_en, o_row_idx, o_blk_last, o_data, o_err
   );

   modport master (
      output i_valid, i_size, i_data, i_ready,
      input  o_ready, o_valid, o_size, o_bfly_en, o_row_idx, o_blk_last, o_data, o_err
   );
endinterface

// File: rtl/tq_row_buf.sv
// tq_row_buf: one row register of 16 raw IN_W samples plus the row's size code.
//  clk, rst_n : clock, asynchronous active-low reset
//  we         : write the 4 samples of beat_data at column beat_idx*4
//  start      : first beat of a row; zero every lane and latch size_in before writing
//  row_o      : 16 stored samples, lane j at [j*IN_W +: IN_W]
//  size_o     : size code of the stored row
module tq_row_buf
   import tq_pkg::*;
#(
   parameter int IN_W = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic                 start,
   input  logic [1:0]           beat_idx,
   input  size_e                size_in,
   input  logic [4*IN_W-1:0]    beat_data,
   output logic [16*IN_W-1:0]   row_o,
   output size_e                size_o
);

   logic [16*IN_W-1:0] row_q, row_d;
   size_e              size_q, size_d;

   // Clearing on the first beat is what guarantees lanes beyond the row size read as 0,
   // and that nothing from a previous (possibly larger) row leaks through.
   always_comb begin
      row_d  = row_q;
      size_d = size_q;
      if (we) begin
         if (start) begin
            row_d  = '0;
            size_d = size_in;
         end
         row_d[int'(beat_idx)*(4*IN_W) +: 4*IN_W] = beat_data;
      end
   end

   // Row storage and its size code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q  <= '0;
         size_q <= SIZE_4;
      end else begin
         row_q  <= row_d;
         size_q <= size_d;
      end
   end

   assign row_o  = row_q;
   assign size_o = size_q;

endmodule

// File: rtl/tq_row_gather.sv
// tq_row_gather: gathers 4-sample beats into 4/8/16-sample rows for the 16-point butterfly.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : tq_row_gather_if slave port (beat input, row output, error flag)
// Two row buffers (ping/pong) form a depth-2 FIFO: one fills while the other is presented.
// Samples are stored raw and sign-extended to OUT_W lanes on the way out.
module tq_row_gather
   import tq_pkg::*;
#(
   parameter int IN_W  = 9,
   parameter int OUT_W = 26
) (
   input  logic                 clk,
   input  logic                 rst_n,
   tq_row_gather_if.slave       bus
);

   logic [1:0]  occ_q, occ_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  beat_cnt_q, beat_cnt_d;
   size_e       row_size_q, row_size_d;
   logic [3:0]  row_idx_q, row_idx_d;
   size_e       blk_size_q, blk_size_d;
   logic        err_q, err_d;
   logic        o_ready_q, o_ready_d;

   logic        accept, first_beat, rsv_beat, store, row_done, retire;
   size_e       beat_size, pres_size, ping_size, pong_size;
   logic [3:0]  last_idx;
   logic [16*IN_W-1:0]  ping_row, pong_row, pres_row;
   logic [16*OUT_W-1:0] data_ext;
   logic [IN_W-1:0]     sample;

   // Beat bookkeeping. The size only comes from i_size on beat 0; later beats
   // use the latched value so a wobbling i_size cannot tear a row.
   always_comb begin
      accept     = bus.i_valid && o_ready_q;
      first_beat = (beat_cnt_q == 2'd0);
      beat_size  = first_beat ? size_e'(bus.i_size) : row_size_q;
      rsv_beat   = accept && first_beat && (bus.i_size == SIZE_RSV);
      store      = accept && !rsv_beat;
      row_done   = store && ({1'b0, beat_cnt_q} == (beats_per_row(beat_size) - 3'd1));
      retire     = (occ_q != 2'd0) && bus.i_ready;
      pres_size  = rd_ptr_q ? pong_size : ping_size;
      pres_row   = rd_ptr_q ? pong_row : ping_row;
      last_idx   = 4'(rows_per_blk(pres_size) - 5'd1);
   end

   tq_row_buf #(.IN_W(IN_W)) u_ping (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (store && !wr_ptr_q),
      .start     (first_beat),
      .beat_idx  (beat_cnt_q),
      .size_in   (beat_size),
      .beat_data (bus.i_data),
      .row_o     (ping_row),
      .size_o    (ping_size)
   );

   tq_row_buf #(.IN_W(IN_W)) u_pong (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (store && wr_ptr_q),
      .start     (first_beat),
      .beat_idx  (beat_cnt_q),
      .size_in   (beat_size),
      .beat_data (bus.i_data),
      .row_o     (pong_row),
      .size_o    (pong_size)
   );

   // Next-state for pointers, occupancy and block position. o_ready is derived from
   // the next occupancy so it drops in the same edge the second row completes.
   always_comb begin
      occ_d      = occ_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      beat_cnt_d = beat_cnt_q;
      row_size_d = row_size_q;
      row_idx_d  = row_idx_q;
      blk_size_d = blk_size_q;
      err_d      = err_q;

      case ({row_done, retire})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase

      if (store) begin
         if (first_beat) row_size_d = beat_size;
         beat_cnt_d = row_done ? 2'd0 : beat_cnt_q + 2'd1;
      end
      if (row_done) wr_ptr_d = !wr_ptr_q;
      if (rsv_beat) err_d = 1'b1;

      // A size change is only legitimate on the first row of a block; otherwise it
      // is still followed, but flagged. The >= wrap keeps a shrink mid-block bounded.
      if (retire) begin
         rd_ptr_d   = !rd_ptr_q;
         blk_size_d = pres_size;
         row_idx_d  = (row_idx_q >= last_idx) ? 4'd0 : row_idx_q + 4'd1;
         if ((row_idx_q != 4'd0) && (pres_size != blk_size_q)) err_d = 1'b1;
      end

      o_ready_d = (occ_d != 2'd2);
   end

   // Control state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q      <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         beat_cnt_q <= 2'd0;
         row_size_q <= SIZE_4;
         row_idx_q  <= 4'd0;
         blk_size_q <= SIZE_4;
         err_q      <= 1'b0;
         o_ready_q  <= 1'b1;
      end else begin
         occ_q      <= occ_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         row_size_q <= row_size_d;
         row_idx_q  <= row_idx_d;
         blk_size_q <= blk_size_d;
         err_q      <= err_d;
         o_ready_q  <= o_ready_d;
      end
   end

   // Sign extension of the presented row into butterfly lanes.
   always_comb begin
      data_ext = '0;
      sample   = '0;
      for (int j = 0; j < 16; j++) begin
         sample = pres_row[j*IN_W +: IN_W];
         data_ext[j*OUT_W +: OUT_W] = {{(OUT_W-IN_W){sample[IN_W-1]}}, sample};
      end
   end

   assign bus.o_ready    = o_ready_q;
   assign bus.o_valid    = (occ_q != 2'd0);
   assign bus.o_size     = pres_size;
   assign bus.o_bfly_en  = (pres_size == SIZE_16);
   assign bus.o_row_idx  = row_idx_q;
   assign bus.o_blk_last = (row_idx_q == last_idx);
   assign bus.o_data     = data_ext;
   assign bus.o_err      = err_q;

endmodule

// File: tb/tb_tq_row_gather.sv
// tb_tq_row_gather: self-checking bench for tq_row_gather.
// A queue-based reference model of completed rows is checked against the DUT on every
// falling edge, and directed scenarios add hand-computed literal expectations.
module tb_tq_row_gather;

   localparam int IN_W  = 9;
   localparam int OUT_W = 26;

   typedef struct packed {
      logic [1:0]          size;
      logic [16*OUT_W-1:0] data;
   } row_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   tq_row_gather_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   tq_row_gather #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: every failure prints one FAIL line.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] lane(input int j);
      return 64'(bus.o_data[j*OUT_W +: OUT_W]);
   endfunction

   function automatic logic [4*IN_W-1:0] packBeat(input int s0, input int s1, input int s2, input int s3);
      return {9'(s3), 9'(s2), 9'(s1), 9'(s0)};
   endfunction

   // Reference model: partial row being assembled, queue of complete rows awaiting retirement,
   // and the expected block position and error flag. Checks the outputs first, then applies
   // whatever handshakes will fire on the coming rising edge.
   row_t exp_q[$];
   int   cur_lanes[16];
   int   cur_beat;
   int   cur_size;
   int   exp_idx;
   int   last_size;
   bit   exp_err;

   always @(negedge clk) begin
      row_t front;
      row_t pushed;
      int   n;
      bit   m_valid;
      bit   m_ready;
      if (!rst_n) begin
         exp_q.delete();
         cur_beat  = 0;
         cur_size  = 0;
         exp_idx   = 0;
         last_size = 0;
         exp_err   = 1'b0;
      end else begin
         m_valid = (exp_q.size() > 0);
         m_ready = (exp_q.size() < 2);
         checkOutput("mdl_o_valid", 64'(bus.o_valid), 64'(m_valid));
         checkOutput("mdl_o_ready", 64'(bus.o_ready), 64'(m_ready));
         checkOutput("mdl_o_err",   64'(bus.o_err),   64'(exp_err));
         if (m_valid) begin
            n = 4 << int'(exp_q[0].size);
            checkOutput("mdl_o_size",     64'(bus.o_size),     64'(exp_q[0].size));
            checkOutput("mdl_o_bfly_en",  64'(bus.o_bfly_en),  64'(exp_q[0].size == 2'd2));
            checkOutput("mdl_o_row_idx",  64'(bus.o_row_idx),  64'(exp_idx));
            checkOutput("mdl_o_blk_last", 64'(bus.o_blk_last), 64'(exp_idx == n - 1));
            checks++;
            if (bus.o_data !== exp_q[0].data) begin
               errors++;
               $display("[TB] FAIL mdl_o_data actual=%h expected=%h", bus.o_data, exp_q[0].data);
            end
         end
         if (m_valid && bus.i_ready) begin
            front = exp_q.pop_front();
            n = 4 << int'(front.size);
            if (exp_idx != 0 && int'(front.size) != last_size) exp_err = 1'b1;
            last_size = int'(front.size);
            exp_idx = (exp_idx + 1 >= n) ? 0 : exp_idx + 1;
         end
         if (bus.i_valid && m_ready) begin
            if (cur_beat == 0 && bus.i_size == 2'd3) begin
               exp_err = 1'b1;
            end else begin
               if (cur_beat == 0) begin
                  cur_size = int'(bus.i_size);
                  for (int j = 0; j < 16; j++) cur_lanes[j] = 0;
               end
               for (int k = 0; k < 4; k++)
                  cur_lanes[cur_beat*4 + k] = int'($signed(bus.i_data[k*IN_W +: IN_W]));
               cur_beat++;
               if (cur_beat == (4 << cur_size) / 4) begin
                  pushed.size = 2'(cur_size);
                  pushed.data = '0;
                  for (int j = 0; j < 16; j++) pushed.data[j*OUT_W +: OUT_W] = OUT_W'(cur_lanes[j]);
                  exp_q.push_back(pushed);
                  cur_beat = 0;
               end
            end
         end
      end
   end

   // Drives one beat and holds it until accepted. Entered and left just after a rising edge.
   task automatic applyStimulus(input logic [1:0] sz, input logic [4*IN_W-1:0] d);
      int   waited;
      logic rdy;
      waited = 0;
      bus.i_valid = 1'b1;
      bus.i_size  = sz;
      bus.i_data  = d;
      do begin
         @(negedge clk);
         rdy = bus.o_ready;
         @(posedge clk);
         #1;
         waited++;
      end while (!rdy && waited < 200);
      checkOutput("beat_accepted", 64'(rdy), 64'd1);
      bus.i_valid = 1'b0;
   endtask

   // Pushes one complete row whose lane j is base + step*j.
   task automatic pushRow(input logic [1:0] sz, input int base, input int step);
      int beats;
      beats = (4 << int'(sz)) / 4;
      for (int b = 0; b < beats; b++)
         applyStimulus(sz, packBeat(base + step*(b*4), base + step*(b*4+1),
                                    base + step*(b*4+2), base + step*(b*4+3)));
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds reset for two cycles, checks every output against its reset value, then releases.
   task automatic resetDut();
      rst_n = 1'b0;
      bus.i_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_o_valid",    64'(bus.o_valid),    64'd0);
      checkOutput("rst_o_ready",    64'(bus.o_ready),    64'd1);
      checkOutput("rst_o_size",     64'(bus.o_size),     64'd0);
      checkOutput("rst_o_bfly_en",  64'(bus.o_bfly_en),  64'd0);
      checkOutput("rst_o_row_idx",  64'(bus.o_row_idx),  64'd0);
      checkOutput("rst_o_blk_last", 64'(bus.o_blk_last), 64'd0);
      checkOutput("rst_o_data_zero", 64'(|bus.o_data),   64'd0);
      checkOutput("rst_o_err",      64'(bus.o_err),      64'd0);
      rst_n = 1'b1;
      idleCycles(1);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_size  = 2'd0;
      bus.i_data  = '0;
      bus.i_ready = 1'b0;
      @(posedge clk);
      #1;

      // Scenario 1: one 16-row of 0..15, valid exactly after the fourth beat.
      resetDut();
      bus.i_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         applyStimulus(2'd2, packBeat(b*4, b*4+1, b*4+2, b*4+3));
         if (b < 3) checkOutput("s1_no_early_valid", 64'(bus.o_valid), 64'd0);
      end
      checkOutput("s1_o_valid",   64'(bus.o_valid),   64'd1);
      checkOutput("s1_o_bfly_en", 64'(bus.o_bfly_en), 64'd1);
      checkOutput("s1_o_row_idx", 64'(bus.o_row_idx), 64'd0);
      for (int j = 0; j < 16; j++) checkOutput("s1_lane", lane(j), 64'(j));
      idleCycles(2);

      // Scenario 2: 4-row with negative samples, sign-extended, upper lanes zero.
      resetDut();
      bus.i_ready = 1'b1;
      applyStimulus(2'd0, packBeat(-1, 2, -3, 4));
      checkOutput("s2_o_valid",   64'(bus.o_valid),   64'd1);
      checkOutput("s2_lane0",     lane(0),            64'h3FFFFFF);
      checkOutput("s2_lane1",     lane(1),            64'd2);
      checkOutput("s2_lane2",     lane(2),            64'h3FFFFFD);
      checkOutput("s2_lane3",     lane(3),            64'd4);
      checkOutput("s2_upper_zero", 64'(|bus.o_data[16*OUT_W-1:4*OUT_W]), 64'd0);
      checkOutput("s2_o_bfly_en", 64'(bus.o_bfly_en), 64'd0);
      checkOutput("s2_blk_last",  64'(bus.o_blk_last), 64'd0);
      idleCycles(2);

      // Scenario 3: back-pressure with three 16-rows; the third must stall until release.
      resetDut();
      bus.i_ready = 1'b0;
      pushRow(2'd2, 100, 1);
      checkOutput("s3_ready_after_row1", 64'(bus.o_ready), 64'd1);
      pushRow(2'd2, 200, 1);
      checkOutput("s3_ready_low",   64'(bus.o_ready), 64'd0);
      checkOutput("s3_row1_lane0",  lane(0),          64'd100);
      fork
         pushRow(2'd2, -50, -1);
         begin
            repeat (3) begin
               @(posedge clk);
               #1;
               checkOutput("s3_hold_ready", 64'(bus.o_ready), 64'd0);
               checkOutput("s3_hold_lane0", lane(0),          64'd100);
               checkOutput("s3_hold_lane15", lane(15),        64'd115);
            end
            bus.i_ready = 1'b1;
         end
      join
      checkOutput("s3_row3_valid",   64'(bus.o_valid),   64'd1);
      checkOutput("s3_row3_lane0",   lane(0),            64'(26'h3FFFFCE));
      checkOutput("s3_row3_row_idx", 64'(bus.o_row_idx), 64'd2);
      idleCycles(2);

      // Scenario 4: a streamed block of eight 8-rows; last flag only on row 7, then wrap.
      resetDut();
      bus.i_ready = 1'b1;
      for (int r = 0; r < 8; r++) begin
         pushRow(2'd1, r*8, 1);
         checkOutput("s4_row_idx",  64'(bus.o_row_idx),  64'(r));
         checkOutput("s4_blk_last", 64'(bus.o_blk_last), 64'(r == 7));
      end
      idleCycles(2);
      checkOutput("s4_wrap_idx", 64'(bus.o_row_idx), 64'd0);

      // Scenario 5: reset in the middle of a 16-row, then a clean row with no stale lanes.
      resetDut();
      bus.i_ready = 1'b1;
      applyStimulus(2'd2, packBeat(-7, -7, -7, -7));
      applyStimulus(2'd2, packBeat(-9, -9, -9, -9));
      resetDut();
      bus.i_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         applyStimulus(2'd2, packBeat(60+b*4, 61+b*4, 62+b*4, 63+b*4));
         if (b < 3) checkOutput("s5_no_early_valid", 64'(bus.o_valid), 64'd0);
      end
      checkOutput("s5_o_valid", 64'(bus.o_valid), 64'd1);
      checkOutput("s5_lane0",   lane(0),          64'd60);
      checkOutput("s5_lane4",   lane(4),          64'd64);
      checkOutput("s5_lane15",  lane(15),         64'd75);
      idleCycles(2);

      // Scenario 6: reserved size sets a sticky error and emits nothing; a 4-row still works.
      resetDut();
      bus.i_ready = 1'b1;
      applyStimulus(2'd3, packBeat(1, 2, 3, 4));
      checkOutput("s6_o_err",   64'(bus.o_err),   64'd1);
      checkOutput("s6_o_valid", 64'(bus.o_valid), 64'd0);
      checkOutput("s6_o_ready", 64'(bus.o_ready), 64'd1);
      idleCycles(3);
      checkOutput("s6_err_sticky", 64'(bus.o_err),   64'd1);
      checkOutput("s6_still_idle", 64'(bus.o_valid), 64'd0);
      applyStimulus(2'd0, packBeat(5, -6, 7, -8));
      checkOutput("s6_row_valid", 64'(bus.o_valid), 64'd1);
      checkOutput("s6_lane0",     lane(0),          64'd5);
      checkOutput("s6_lane1",     lane(1),          64'h3FFFFFA);
      checkOutput("s6_lane3",     lane(3),          64'h3FFFFF8);
      checkOutput("s6_err_kept",  64'(bus.o_err),   64'd1);
      idleCycles(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
